charlieplex_scan: RTL

Scan controller for the 7-pin charlieplexed LED matrix (42 LEDs). It holds a per-LED brightness framebuffer written by the register side and sequences one anode row at a time. Each row gets a blanking interval followed by a PWM drive window. It produces the charlieplex output-enable and output-value vectors that feed the tristate IO cell on the board top.

---
 rtl/charlieplex_scan_if.sv | 23 ++
 rtl/charlieplex_scan.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/charlieplex_scan_if.sv
// rtl/charlieplex_scan_if.sv - framebuffer write port bundle for charlieplex_scan
interface charlieplex_scan_if #(
  parameter int PWM_BITS = 4
);
  logic                wr_stb;
  logic [5:0]          wr_addr;
  logic [PWM_BITS-1:0] wr_data;
  logic                wr_ack;

  modport master (
    output wr_stb,
    output wr_addr,
    output wr_data,
    input  wr_ack
  );

  modport slave (
    input  wr_stb,
    input  wr_addr,
    input  wr_data,
    output wr_ack
  );
endinterface

// File: rtl/charlieplex_scan.sv
// rtl/charlieplex_scan.sv - 7-pin charlieplex LED scan controller with per-LED PWM brightness
// Defining CHARLIEPLEX_DOUBLE_BUFFER_EN adds a front/back framebuffer swapped at frame start.
module charlieplex_scan #(
  parameter int TICKS_PER_STEP = 64,
  parameter int BLANK_TICKS    = 16,
  parameter int PWM_BITS       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  charlieplex_scan_if.slave wr,
  input  logic              swap,
  output logic              swap_done,
  output logic              frame_pulse,
  output logic [6:0]        charlieplex_oe,
  output logic [6:0]        charlieplex_o
);
  localparam int NUM_LEDS = 42;
  localparam int TICK_MAX = (TICKS_PER_STEP > BLANK_TICKS) ? TICKS_PER_STEP : BLANK_TICKS;
  localparam int TW       = $clog2(TICK_MAX + 1);
  localparam logic [TW-1:0]       BLANK_LAST = TW'(BLANK_TICKS - 1);
  localparam logic [TW-1:0]       STEP_LAST  = TW'(TICKS_PER_STEP - 1);
  localparam logic [PWM_BITS-1:0] STEP_MAX   = '1;

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t              state, state_n;
  logic [2:0]          row, row_n;
  logic [PWM_BITS-1:0] step, step_n;
  logic [TW-1:0]       tick, tick_n;
  logic                new_frame;
  logic [6:0]          oe_n, o_n;
  logic [5:0]          idx;
  logic [PWM_BITS-1:0] lvl;
  logic                wr_hit;

  assign wr_hit = wr.wr_stb && (wr.wr_addr < 6'(NUM_LEDS));

`ifdef CHARLIEPLEX_DOUBLE_BUFFER_EN
  logic [PWM_BITS-1:0] fb [2][NUM_LEDS];
  logic                front;
  logic                swap_pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        fb[0][i] <= '0;
        fb[1][i] <= '0;
      end
    end else if (wr_hit) begin
      fb[~front][wr.wr_addr] <= wr.wr_data;
    end
  end

  // A swap requested in the same cycle as the frame boundary still lands on that boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front        <= 1'b0;
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
    end else begin
      swap_done <= 1'b0;
      if (new_frame && (swap_pending || swap)) begin
        front        <= ~front;
        swap_pending <= 1'b0;
        swap_done    <= 1'b1;
      end else if (swap) begin
        swap_pending <= 1'b1;
      end
    end
  end
`else
  logic [PWM_BITS-1:0] fb [NUM_LEDS];
  logic                unused_swap;

  assign unused_swap = swap;
  assign swap_done   = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LEDS; i++) fb[i] <= '0;
    end else if (wr_hit) begin
      fb[wr.wr_addr] <= wr.wr_data;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      row            <= '0;
      step           <= '0;
      tick           <= '0;
      frame_pulse    <= 1'b0;
      charlieplex_oe <= '0;
      charlieplex_o  <= '0;
      wr.wr_ack      <= 1'b0;
    end else begin
      state          <= state_n;
      row            <= row_n;
      step           <= step_n;
      tick           <= tick_n;
      frame_pulse    <= new_frame;
      charlieplex_oe <= oe_n;
      charlieplex_o  <= o_n;
      wr.wr_ack      <= wr.wr_stb;
    end
  end

  always_comb begin
    state_n   = state;
    row_n     = row;
    step_n    = step;
    tick_n    = tick;
    new_frame = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      row_n   = '0;
      step_n  = '0;
      tick_n  = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n   = BLANK;
          row_n     = '0;
          step_n    = '0;
          tick_n    = '0;
          new_frame = 1'b1;
        end
        BLANK: begin
          if (tick == BLANK_LAST) begin
            state_n = DRIVE;
            step_n  = '0;
            tick_n  = '0;
          end else begin
            tick_n = tick + TW'(1);
          end
        end
        DRIVE: begin
          if (tick == STEP_LAST) begin
            tick_n = '0;
            if (step == STEP_MAX) begin
              state_n = BLANK;
              step_n  = '0;
              if (row == 3'd6) begin
                row_n     = '0;
                new_frame = 1'b1;
              end else begin
                row_n = row + 3'd1;
              end
            end else begin
              step_n = step + PWM_BITS'(1);
            end
          end else begin
            tick_n = tick + TW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Row pin is the anode; the other six pins are the cathodes of that row's LEDs.
  always_comb begin
    oe_n = '0;
    o_n  = '0;
    idx  = '0;
    lvl  = '0;
    if (state == DRIVE) begin
      for (int c = 0; c < 7; c++) begin
        if (c == int'(row)) begin
          oe_n[c] = 1'b1;
          o_n[c]  = 1'b1;
        end else begin
          idx = 6'(int'(row) * 6 + ((c < int'(row)) ? c : c - 1));
`ifdef CHARLIEPLEX_DOUBLE_BUFFER_EN
          lvl = fb[front][idx];
`else
          lvl = fb[idx];
`endif
          oe_n[c] = (lvl > step);
        end
      end
    end
  end
endmodule
